uart_tx_sched: RTL

- Round-robin scheduler that shares one uart_tx byte transmitter among N client requesters.
- Each client uses the codebase toggle handshake: it toggles a request and receives an ack toggle once its byte has been fully shifted out.
- The block drives uart_tx's toggle req/tx_data and consumes its ack toggle. It adds an optional completion timeout that reports errors per client.

---
 rtl/uart_tx_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one toggle-handshake uart_tx among N clients,
// with an optional completion timeout reported as sticky per-client errors.
module uart_tx_sched #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           enable,
    input  logic [N-1:0]   cli_req,
    input  logic [8*N-1:0] cli_data,
    output logic [N-1:0]   cli_ack,
    output logic           tx_req,
    output logic [7:0]     tx_data,
    input  logic           tx_ack,
    input  logic [31:0]    timeout,
    output logic [N-1:0]   err,
    input  logic [N-1:0]   err_clr,
    output logic [IW-1:0]  grant,
    output logic           busy,
    output logic [1:0]     cst
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] WAIT  = 2'b11;
    localparam logic [1:0] DONE  = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  req_s1_q, req_s2_q;
    logic          ack_s1_q, ack_s2_q;
    logic [N-1:0]  cli_ack_q, cli_ack_d;
    logic          tx_req_q, tx_req_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [N-1:0]  err_q, err_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [31:0]   timer_q, timer_d;

    logic [N-1:0]  pending;
    logic          downstream_idle;
    logic          pick_vld;
    logic [IW-1:0] pick;
    logic [7:0]    pick_byte;
    int unsigned   cand;

    assign pending         = req_s2_q ^ cli_ack_q;
    assign downstream_idle = (ack_s2_q == tx_req_q);

    // First pending client found scanning ptr, ptr+1, ... modulo N.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_q) + k) % N;
            for (int unsigned j = 0; j < N; j++) begin
                if (!pick_vld && j == cand && pending[j]) begin
                    pick_vld = 1'b1;
                    pick     = IW'(j);
                end
            end
        end
    end

    always_comb begin
        pick_byte = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(pick) == k) pick_byte = cli_data[8*k +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cli_ack_d = cli_ack_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        err_d     = err_q & ~err_clr;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld && downstream_idle) begin
                    grant_d   = pick;
                    tx_data_d = pick_byte;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                tx_req_d = ~tx_req_q;
                timer_d  = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (ack_s2_q == tx_req_q) begin
                    state_d = DONE;
                end else if (timeout != '0 && timer_q == timeout - 32'd1) begin
                    // OR after the clear so a same-cycle set wins
                    err_d   = err_d | (N'(1) << grant_q);
                    state_d = DONE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 32'd1;
                end
            end
            DONE: begin
                cli_ack_d = cli_ack_q ^ (N'(1) << grant_q);
                ptr_d     = IW'((32'(grant_q) + 32'd1) % N);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            req_s1_q  <= '0;
            req_s2_q  <= '0;
            ack_s1_q  <= 1'b0;
            ack_s2_q  <= 1'b0;
            cli_ack_q <= '0;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            err_q     <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
        end else if (enable) begin
            state_q   <= state_d;
            req_s1_q  <= cli_req;
            req_s2_q  <= req_s1_q;
            ack_s1_q  <= tx_ack;
            ack_s2_q  <= ack_s1_q;
            cli_ack_q <= cli_ack_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
        end
    end

    assign cli_ack = cli_ack_q;
    assign tx_req  = tx_req_q;
    assign tx_data = tx_data_q;
    assign err     = err_q;
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign cst     = state_q;

endmodule
